// File: rtl/obi_lsu_pkg.sv
// Shared types for the OBI load/store unit: access direction, FSM state encoding
// and the per-transaction record kept in the response-tracking FIFO.
package obi_lsu_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rdwr;

    typedef logic [1:0] t_lsu_state;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_ADDR = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;

    typedef struct packed {
        rdwr we;
    } lsu_txn;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/obi_lsu_txn_fifo.sv
// In-order record of issued OBI transactions awaiting rvalid; push and pop in the
// same cycle are accepted even when full, since the pop frees the slot being written.
module obi_lsu_txn_fifo
    import obi_lsu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/obi_lsu.sv
// Load/store unit between the MEM stage and a data-side OBI master port.
// Optional LSU_MISALIGN_CHK_EN adds misalign_o and suppresses misaligned full-word accesses.
//
// state    | meaning
// LSU_IDLE | no request on the bus; accept a new access if a slot is free
// LSU_ADDR | obi_req_o high, request fields frozen until gnt
// LSU_RESP | load granted, waiting for its rvalid at the FIFO head
module obi_lsu
    import obi_lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_en_i,
    input  rdwr                 we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic                lsu_stall_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rdata_valid_o,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic                obi_we_o,
    output logic [DATA_W/8-1:0] obi_be_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic                misalign_o
`endif
);

    localparam int BE_W = DATA_W / 8;

    t_lsu_state          state_q;
    t_lsu_state          state_d;
    logic [ADDR_W-1:0]   addr_q;
    rdwr                 we_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rdata_valid_q;

    lsu_txn              push_txn;
    logic [$bits(lsu_txn)-1:0] head_raw;
    lsu_txn              head_txn;
    logic                fifo_full;
    logic                fifo_empty;

    logic                idle_ready;
    logic                misalign_hit;
    logic                issue;
    logic                gnt_fire;
    logic                load_done;
    logic                retire;

    // The cycle after a load completes still shows that load on mem_en_i; it must not re-issue.
    assign idle_ready = (state_q == LSU_IDLE) & mem_en_i & ~rdata_valid_q;

`ifdef LSU_MISALIGN_CHK_EN
    assign misalign_hit = idle_ready
                        & ((addr_i & ADDR_W'(BE_W - 1)) != '0)
                        & (be_i == '1);
    assign misalign_o   = misalign_hit;
    assign obi_addr_o   = addr_q;
`else
    assign misalign_hit = 1'b0;
    assign obi_addr_o   = addr_q & ~ADDR_W'(BE_W - 1);
`endif

    assign issue     = idle_ready & ~misalign_hit & ~fifo_full;
    assign gnt_fire  = (state_q == LSU_ADDR) & obi_gnt_i;
    assign head_txn  = lsu_txn'(head_raw);
    assign load_done = (state_q == LSU_RESP) & obi_rvalid_i & ~fifo_empty
                     & (head_txn.we == READ);
    assign retire    = rdata_valid_q | (gnt_fire & (we_q == WRITE)) | misalign_hit;

    assign lsu_stall_o   = mem_en_i & ~retire;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign obi_req_o     = (state_q == LSU_ADDR);
    assign obi_we_o      = (we_q == WRITE);
    assign obi_be_o      = be_q;
    assign obi_wdata_o   = wdata_q;

    always_comb begin
        push_txn    = '0;
        push_txn.we = we_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (issue) state_d = LSU_ADDR;
            LSU_ADDR: if (obi_gnt_i) state_d = (we_q == WRITE) ? LSU_IDLE : LSU_RESP;
            LSU_RESP: if (load_done) state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LSU_IDLE;
            addr_q        <= '0;
            we_q          <= READ;
            be_q          <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_valid_q <= load_done;
            if (issue) begin
                addr_q  <= addr_i;
                we_q    <= we_i;
                be_q    <= be_i;
                wdata_q <= wdata_i;
            end
            if (load_done) rdata_q <= obi_rdata_i;
        end
    end

    // Every rvalid pops one entry; stray rvalid on an empty FIFO is dropped inside.
    obi_lsu_txn_fifo #(
        .DEPTH (MAX_OUTST),
        .W     ($bits(lsu_txn))
    ) u_txn_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (gnt_fire),
        .push_data (push_txn),
        .pop       (obi_rvalid_i),
        .head      (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_obi_lsu.sv
// Self-checking bench for obi_lsu; load data is checked through a scoreboard queue
// filled when rvalid is driven and drained when rdata_valid_o pulses.
module tb_obi_lsu;
    import obi_lsu_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_en = 1'b0;
    rdwr               we = READ;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        be = '0;
    logic              lsu_stall;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              obi_req;
    logic              obi_gnt = 1'b0;
    logic [ADDR_W-1:0] obi_addr;
    logic              obi_we;
    logic [3:0]        obi_be;
    logic [DATA_W-1:0] obi_wdata;
    logic              obi_rvalid = 1'b0;
    logic [DATA_W-1:0] obi_rdata = '0;
`ifdef LSU_MISALIGN_CHK_EN
    logic              misalign;
`endif

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] sb[$];

    always #5 clk = ~clk;

    obi_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_OUTST(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_en_i      (mem_en),
        .we_i          (we),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .be_i          (be),
        .lsu_stall_o   (lsu_stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .obi_req_o     (obi_req),
        .obi_gnt_i     (obi_gnt),
        .obi_addr_o    (obi_addr),
        .obi_we_o      (obi_we),
        .obi_be_o      (obi_be),
        .obi_wdata_o   (obi_wdata),
        .obi_rvalid_i  (obi_rvalid),
        .obi_rdata_i   (obi_rdata)
`ifdef LSU_MISALIGN_CHK_EN
        ,
        .misalign_o    (misalign)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard consumer: every load-data pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (rdata_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: rdata_valid_o pulsed with rdata_o=%h, no load expected", rdata);
            end else begin
                logic [DATA_W-1:0] exp_d;
                exp_d = sb.pop_front();
                if (rdata !== exp_d) begin
                    failures++;
                    $display("FAIL sb_rdata: got %h expected %h", rdata, exp_d);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        mem_en = 1'b0;
        repeat (3) @(posedge clk);
        smp();
        checks++;
        if ({obi_req, lsu_stall, rdata_valid, obi_we} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: req/stall/rvalid/we=%b expected 0000",
                     {obi_req, lsu_stall, rdata_valid, obi_we});
        end
        checks++;
        if ({rdata, obi_addr, obi_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected 0", rdata, obi_addr, obi_wdata);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        tick();
        mem_en = 1'b1; we = WRITE; addr = 32'h100; wdata = 32'hDEADBEEF; be = 4'hF; obi_gnt = 1'b1;
        smp();
        checks++;
        if ({lsu_stall, obi_req} !== 2'b10) begin
            failures++;
            $display("FAIL store_idle: stall/req=%b expected 10", {lsu_stall, obi_req});
        end
        tick();
        smp();
        checks++;
        if ({obi_req, obi_we, lsu_stall} !== 3'b110 || obi_addr !== 32'h100 ||
            obi_wdata !== 32'hDEADBEEF || obi_be !== 4'hF) begin
            failures++;
            $display("FAIL store_gnt: req/we/stall=%b addr=%h wdata=%h be=%h expected 110 100 deadbeef f",
                     {obi_req, obi_we, lsu_stall}, obi_addr, obi_wdata, obi_be);
        end
        tick();
        mem_en = 1'b0; obi_gnt = 1'b0;
        smp();
        checks++;
        if ({obi_req, lsu_stall} !== 2'b00) begin
            failures++;
            $display("FAIL store_req_len: req/stall=%b expected 00", {obi_req, lsu_stall});
        end
        tick();
        obi_rvalid = 1'b1; obi_rdata = 32'hFFFF0000;
        tick();
        obi_rvalid = 1'b0;
        smp();
        checks++;
        if (rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL store_resp_discard: rdata_valid_o=%b expected 0", rdata_valid);
        end
    endtask

    task automatic test_load();
        tick();
        mem_en = 1'b1; we = READ; addr = 32'h104; wdata = '0; be = 4'hF; obi_gnt = 1'b0;
        smp();
        checks++;
        if ({lsu_stall, obi_req} !== 2'b10) begin
            failures++;
            $display("FAIL load_idle: stall/req=%b expected 10", {lsu_stall, obi_req});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            obi_gnt = (k == 3);
            smp();
            checks++;
            if ({obi_req, lsu_stall, obi_we} !== 3'b110 || obi_addr !== 32'h104) begin
                failures++;
                $display("FAIL load_addr_hold[%0d]: req/stall/we=%b addr=%h expected 110 104",
                         k, {obi_req, lsu_stall, obi_we}, obi_addr);
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            obi_gnt = 1'b0;
            smp();
            checks++;
            if ({obi_req, lsu_stall} !== 2'b01) begin
                failures++;
                $display("FAIL load_resp_wait[%0d]: req/stall=%b expected 01", k, {obi_req, lsu_stall});
            end
        end
        tick();
        obi_rvalid = 1'b1; obi_rdata = 32'h12345678;
        sb.push_back(32'h12345678);
        smp();
        checks++;
        if ({lsu_stall, rdata_valid} !== 2'b10) begin
            failures++;
            $display("FAIL load_rvalid_cycle: stall/rdata_valid=%b expected 10", {lsu_stall, rdata_valid});
        end
        tick();
        obi_rvalid = 1'b0;
        smp();
        checks++;
        if ({rdata_valid, lsu_stall} !== 2'b10 || rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL load_pulse: rdata_valid/stall=%b rdata=%h expected 10 12345678",
                     {rdata_valid, lsu_stall}, rdata);
        end
        tick();
        mem_en = 1'b0;
        smp();
        checks++;
        if ({rdata_valid, obi_req} !== 2'b00) begin
            failures++;
            $display("FAIL load_pulse_len: rdata_valid/req=%b expected 00", {rdata_valid, obi_req});
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        obi_gnt = 1'b1;
        for (int s = 0; s < 2; s++) begin
            tick();
            mem_en = 1'b1; we = WRITE; a = 32'h200 + 32'(4 * s); addr = a; be = 4'hF;
            wdata = 32'hA0000000 + 32'(s);
            smp();
            checks++;
            if ({lsu_stall, obi_req} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_idle[%0d]: stall/req=%b expected 10", s, {lsu_stall, obi_req});
            end
            tick();
            smp();
            checks++;
            if ({obi_req, lsu_stall} !== 2'b10 || obi_addr !== a) begin
                failures++;
                $display("FAIL b2b_issue[%0d]: req/stall=%b addr=%h expected 10 %h",
                         s, {obi_req, lsu_stall}, obi_addr, a);
            end
        end
        tick();
        addr = 32'h208; wdata = 32'hA0000002;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) obi_rvalid = 1'b1;
            if (k == 4) obi_rvalid = 1'b0;
            smp();
            checks++;
            if ({obi_req, lsu_stall} !== 2'b01) begin
                failures++;
                $display("FAIL b2b_full_stall[%0d]: req/stall=%b expected 01", k, {obi_req, lsu_stall});
            end
            if (k < 4) tick();
        end
        tick();
        smp();
        checks++;
        if ({obi_req, lsu_stall} !== 2'b10 || obi_addr !== 32'h208) begin
            failures++;
            $display("FAIL b2b_third_issue: req/stall=%b addr=%h expected 10 208",
                     {obi_req, lsu_stall}, obi_addr);
        end
        tick();
        mem_en = 1'b0; obi_rvalid = 1'b1;
        tick();
        tick();
        obi_rvalid = 1'b0;
    endtask

    task automatic test_store_load();
        obi_gnt = 1'b1;
        tick();
        mem_en = 1'b1; we = WRITE; addr = 32'h300; wdata = 32'h11112222; be = 4'hF;
        tick();
        smp();
        checks++;
        if ({obi_req, obi_we, lsu_stall} !== 3'b110) begin
            failures++;
            $display("FAIL sl_store: req/we/stall=%b expected 110", {obi_req, obi_we, lsu_stall});
        end
        tick();
        we = READ; addr = 32'h304; wdata = '0;
        tick();
        smp();
        checks++;
        if ({obi_req, obi_we, lsu_stall} !== 3'b101 || obi_addr !== 32'h304) begin
            failures++;
            $display("FAIL sl_load: req/we/stall=%b addr=%h expected 101 304",
                     {obi_req, obi_we, lsu_stall}, obi_addr);
        end
        tick();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hBAD0BAD0;
        smp();
        checks++;
        if (lsu_stall !== 1'b1) begin
            failures++;
            $display("FAIL sl_first_rvalid_stall: stall=%b expected 1", lsu_stall);
        end
        tick();
        obi_rdata = 32'hCAFEF00D;
        sb.push_back(32'hCAFEF00D);
        smp();
        checks++;
        if ({rdata_valid, lsu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL sl_write_discard: rdata_valid/stall=%b expected 01", {rdata_valid, lsu_stall});
        end
        tick();
        obi_rvalid = 1'b0;
        smp();
        checks++;
        if ({rdata_valid, lsu_stall} !== 2'b10 || rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL sl_load_data: rdata_valid/stall=%b rdata=%h expected 10 cafef00d",
                     {rdata_valid, lsu_stall}, rdata);
        end
        tick();
        mem_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        obi_gnt = 1'b1;
        tick();
        mem_en = 1'b1; we = READ; addr = 32'h400; be = 4'hF;
        tick();
        tick();
        obi_gnt = 1'b0;
        smp();
        checks++;
        if ({obi_req, lsu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_resp: req/stall=%b expected 01", {obi_req, lsu_stall});
        end
        tick();
        rst_n = 1'b0; mem_en = 1'b0;
        tick();
        rst_n = 1'b1; obi_rvalid = 1'b1; obi_rdata = 32'h55555555;
        smp();
        checks++;
        if ({obi_req, lsu_stall, rdata_valid} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_idle: req/stall/rdata_valid=%b expected 000",
                     {obi_req, lsu_stall, rdata_valid});
        end
        tick();
        obi_rvalid = 1'b0;
        smp();
        checks++;
        if (rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_late_rvalid: rdata_valid=%b expected 0", rdata_valid);
        end
        // Two stores must issue and the third must block: the count restarted at zero.
        obi_gnt = 1'b1;
        tick();
        mem_en = 1'b1; we = WRITE; addr = 32'h500; be = 4'hF;
        tick();
        tick();
        addr = 32'h504;
        tick();
        smp();
        checks++;
        if ({obi_req, lsu_stall} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_count_second: req/stall=%b expected 10", {obi_req, lsu_stall});
        end
        tick();
        addr = 32'h508;
        tick();
        smp();
        checks++;
        if ({obi_req, lsu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_count_third: req/stall=%b expected 01", {obi_req, lsu_stall});
        end
        tick();
        mem_en = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b1;
        tick();
        tick();
        obi_rvalid = 1'b0;
    endtask

`ifdef LSU_MISALIGN_CHK_EN
    task automatic test_misalign();
        obi_gnt = 1'b1;
        tick();
        mem_en = 1'b1; we = READ; addr = 32'h102; be = 4'hF;
        smp();
        checks++;
        if ({misalign, lsu_stall, obi_req} !== 3'b100) begin
            failures++;
            $display("FAIL misalign_pulse: misalign/stall/req=%b expected 100", {misalign, lsu_stall, obi_req});
        end
        tick();
        mem_en = 1'b0;
        smp();
        checks++;
        if ({misalign, obi_req} !== 2'b00) begin
            failures++;
            $display("FAIL misalign_no_traffic: misalign/req=%b expected 00", {misalign, obi_req});
        end
        obi_gnt = 1'b0;
    endtask
`else
    task automatic test_addr_mask();
        obi_gnt = 1'b1;
        tick();
        mem_en = 1'b1; we = WRITE; addr = 32'h102; wdata = 32'h0BADCAFE; be = 4'hF;
        tick();
        smp();
        checks++;
        if (obi_req !== 1'b1 || obi_addr !== 32'h100) begin
            failures++;
            $display("FAIL addr_mask: req=%b addr=%h expected 1 100", obi_req, obi_addr);
        end
        tick();
        mem_en = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b1;
        tick();
        obi_rvalid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_store_load();
        test_reset_mid();
`ifdef LSU_MISALIGN_CHK_EN
        test_misalign();
`else
        test_addr_mask();
`endif
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d load results never returned, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
